// File: rtl/rf_wb_scoreboard.sv
// rf_wb_scoreboard: 16 x 32-bit register file with a writeback port,
// two combinational read ports and a per-register pending-write scoreboard.
// R0 is hardwired to zero and is never marked pending.
// Optional build macro: RF_BYPASS_EN adds same-cycle write-to-read forwarding
// and hides the busy flag of a register being written this cycle.
module rf_wb_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [ADDR_W-1:0] read_rega,
  input  logic [ADDR_W-1:0] read_regb,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_reg,
  output logic [DATA_W-1:0] rsa,
  output logic [DATA_W-1:0] rsb,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   sb_q, sb_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;
  logic              wr_ok, mark_ok;

  assign wr_ok   = rf_we && (write_reg != '0);
  assign mark_ok = mark_en && (mark_reg != '0);

  // Next scoreboard: the write retires the older instruction first, so a
  // same-register mark in the same cycle leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (rf_we) sb_d[write_reg] = 1'b0;
    if (mark_ok) sb_d[mark_reg] = 1'b1;
    sb_d[0] = 1'b0;
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(sb_d[i]);
  end

  // Register array writeback; R0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // Scoreboard bits and their registered population count.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      sb_q       <= '0;
      pend_cnt_q <= '0;
    end else begin
      sb_q       <= sb_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

`ifdef RF_BYPASS_EN
  logic fwd_a, fwd_b;
  assign fwd_a = wr_ok && (read_rega == write_reg);
  assign fwd_b = wr_ok && (read_regb == write_reg);

  // Read ports with same-cycle forwarding of the writeback data.
  always_comb begin
    rsa    = fwd_a ? write_data : regs_q[read_rega];
    rsb    = fwd_b ? write_data : regs_q[read_regb];
    busy_a = sb_q[read_rega] && !(fwd_a && !(mark_ok && mark_reg == read_rega));
    busy_b = sb_q[read_regb] && !(fwd_b && !(mark_ok && mark_reg == read_regb));
  end
`else
  // Read ports return array contents; busy flags mirror the scoreboard.
  always_comb begin
    rsa    = regs_q[read_rega];
    rsb    = regs_q[read_regb];
    busy_a = sb_q[read_rega];
    busy_b = sb_q[read_regb];
  end
`endif

endmodule
